hazard_controller: RTL and testbench

Pipeline hazard controller that sequences the instruction-fetch stage and IF/ID, ID/EX boundaries of the five-stage core. It owns the fetch stage's `pcWrite`, `ifIdWrite`, `branch` and `branchProgramCounter` inputs. It combines load-use detection, taken-branch redirect with configurable flush depth, and data-memory wait holds into one FSM. A saturating stall counter supports performance debug.

---
 rtl/hazard_controller_pkg.sv | 9 +
 rtl/hazard_controller_if.sv | 34 +++
 rtl/hazard_controller_load_use_detector.sv | 16 +
 rtl/hazard_controller.sv | 133 +++++++++++++
 tb/tb_hazard_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// hazard_pkg: shared FSM state type and register-index width for the hazard controller
// Ports: none (package)
package hazard_pkg;
    localparam int REG_W = 5;
    typedef enum logic [1:0] {RUN, LOAD_STALL, REDIRECT, MEM_WAIT} state_t;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline-side hazard inputs and fetch/boundary control outputs
// Ports (master = pipeline, slave = controller):
//   *_i  idRs/idRt/idUsesRt, idExMemRead/idExRt, branchTaken/branchTarget, memBusy
//   *_o  pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemHold, branch, branchProgramCounter, stallCount
interface hazard_controller_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    import hazard_pkg::*;
    logic [REG_W-1:0]       idRs_i;
    logic [REG_W-1:0]       idRt_i;
    logic                   idUsesRt_i;
    logic                   idExMemRead_i;
    logic [REG_W-1:0]       idExRt_i;
    logic                   branchTaken_i;
    logic [ADDR_WIDTH-1:0]  branchTarget_i;
    logic                   memBusy_i;
    logic                   pcWrite_o;
    logic                   ifIdWrite_o;
    logic                   ifIdFlush_o;
    logic                   idExBubble_o;
    logic                   exMemHold_o;
    logic                   branch_o;
    logic [ADDR_WIDTH-1:0]  branchProgramCounter_o;
    logic [COUNT_WIDTH-1:0] stallCount_o;
    modport master (
        output idRs_i, idRt_i, idUsesRt_i, idExMemRead_i, idExRt_i, branchTaken_i, branchTarget_i, memBusy_i,
        input  pcWrite_o, ifIdWrite_o, ifIdFlush_o, idExBubble_o, exMemHold_o, branch_o, branchProgramCounter_o, stallCount_o
    );
    modport slave (
        input  idRs_i, idRt_i, idUsesRt_i, idExMemRead_i, idExRt_i, branchTaken_i, branchTarget_i, memBusy_i,
        output pcWrite_o, ifIdWrite_o, ifIdFlush_o, idExBubble_o, exMemHold_o, branch_o, branchProgramCounter_o, stallCount_o
    );
endinterface

// File: rtl/hazard_controller_load_use_detector.sv
// load_use_detector: flags an ID instruction reading the destination of a load currently in EX
// Ports: idRs_i/idRt_i/idUsesRt_i (ID sources), idExMemRead_i/idExRt_i (EX load), hazard_o
module load_use_detector
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] idRs_i,
    input  logic [REG_W-1:0] idRt_i,
    input  logic             idUsesRt_i,
    input  logic             idExMemRead_i,
    input  logic [REG_W-1:0] idExRt_i,
    output logic             hazard_o
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard_o = idExMemRead_i && idExRt_i != '0 &&
                      (idExRt_i == idRs_i || (idUsesRt_i && idExRt_i == idRt_i));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: Mealy FSM sequencing load-use stalls, branch redirects and data-memory holds
// Ports: clk, reset (sync, active-high), bus (hazard_controller_if.slave: hazard inputs, fetch/boundary controls, stallCount)
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int REDIRECT_CYCLES = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input logic clk,
    input logic reset,
    hazard_controller_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(LOAD_USE_CYCLES, REDIRECT_CYCLES) + 1);
    // cnt counts remaining cycles after the current one, so entry loads N-2
    localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LOAD_USE_CYCLES > 1 ? LOAD_USE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(REDIRECT_CYCLES > 1 ? REDIRECT_CYCLES - 2 : 0);
    localparam state_t LU_NEXT = (LOAD_USE_CYCLES > 1) ? LOAD_STALL : RUN;
    localparam state_t RD_NEXT = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;

    state_t                 state_q, state_d, saved_q, saved_d, act_state;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0]  pend_target_q, pend_target_d;
    logic [COUNT_WIDTH-1:0] stall_count_q;
    logic                   hazard, cnt_done;
    logic                   pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, branch;
    logic [ADDR_WIDTH-1:0]  branch_pc;

    load_use_detector u_det (
        .idRs_i        (bus.idRs_i),
        .idRt_i        (bus.idRt_i),
        .idUsesRt_i    (bus.idUsesRt_i),
        .idExMemRead_i (bus.idExMemRead_i),
        .idExRt_i      (bus.idExRt_i),
        .hazard_o      (hazard)
    );

    // leaving a memory wait resumes whatever was interrupted, with cnt untouched
    assign act_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    assign cnt_done  = cnt_q == '0;

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_hold   = 1'b0;
        branch        = 1'b0;
        branch_pc     = '0;
        state_d       = state_q;
        saved_d       = saved_q;
        cnt_d         = cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (bus.memBusy_i) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            state_d     = MEM_WAIT;
            saved_d     = (state_q == MEM_WAIT) ? saved_q : state_q;
            if (bus.branchTaken_i) begin
                pend_valid_d  = 1'b1;
                pend_target_d = bus.branchTarget_i;
            end
        end else if (bus.branchTaken_i || pend_valid_q) begin
            branch       = 1'b1;
            branch_pc    = pend_valid_q ? pend_target_q : bus.branchTarget_i;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = RD_NEXT;
            cnt_d        = RD_INIT;
        end else begin
            case (act_state)
                LOAD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = cnt_done ? RUN : LOAD_STALL;
                    cnt_d        = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
                end
                REDIRECT: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = cnt_done ? RUN : REDIRECT;
                    cnt_d        = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
                end
                default: begin
                    pc_write     = !hazard;
                    if_id_write  = !hazard;
                    id_ex_bubble = hazard;
                    state_d      = hazard ? LU_NEXT : RUN;
                    cnt_d        = hazard ? LU_INIT : cnt_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            saved_q       <= RUN;
            cnt_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            saved_q       <= saved_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            if (!pc_write && stall_count_q != '1)
                stall_count_q <= stall_count_q + COUNT_WIDTH'(1);
        end
    end

    assign bus.pcWrite_o              = pc_write;
    assign bus.ifIdWrite_o            = if_id_write;
    assign bus.ifIdFlush_o            = if_id_flush;
    assign bus.idExBubble_o           = id_ex_bubble;
    assign bus.exMemHold_o            = ex_mem_hold;
    assign bus.branch_o               = branch;
    assign bus.branchProgramCounter_o = branch_pc;
    assign bus.stallCount_o           = stall_count_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of two controller configurations (A: 2/2/16-bit, B: 3/1/3-bit)
module tb_hazard_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, idExRt;
    logic        idUsesRt, idExMemRead, branchTaken, memBusy;
    logic [31:0] branchTarget;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) ha ();
    hazard_controller_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(3))  hb ();

    assign ha.idRs_i = idRs;               assign hb.idRs_i = idRs;
    assign ha.idRt_i = idRt;               assign hb.idRt_i = idRt;
    assign ha.idUsesRt_i = idUsesRt;       assign hb.idUsesRt_i = idUsesRt;
    assign ha.idExMemRead_i = idExMemRead; assign hb.idExMemRead_i = idExMemRead;
    assign ha.idExRt_i = idExRt;           assign hb.idExRt_i = idExRt;
    assign ha.branchTaken_i = branchTaken; assign hb.branchTaken_i = branchTaken;
    assign ha.branchTarget_i = branchTarget; assign hb.branchTarget_i = branchTarget;
    assign ha.memBusy_i = memBusy;         assign hb.memBusy_i = memBusy;

    hazard_controller #(.ADDR_WIDTH(32), .LOAD_USE_CYCLES(2), .REDIRECT_CYCLES(2), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ha)
    );
    hazard_controller #(.ADDR_WIDTH(32), .LOAD_USE_CYCLES(3), .REDIRECT_CYCLES(1), .COUNT_WIDTH(3)) dut_b (
        .clk(clk), .reset(reset), .bus(hb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idRs = '0; idRt = '0; idExRt = '0; idUsesRt = 1'b0; idExMemRead = 1'b0;
        branchTaken = 1'b0; branchTarget = '0; memBusy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_hazard();
        idExMemRead = 1'b1; idExRt = 5'd5; idRs = 5'd5;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #2;
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL rst_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        checks++; if (ha.ifIdWrite_o !== 1'b0) begin errors++; $display("FAIL rst_ifIdWrite got=%0h exp=0", ha.ifIdWrite_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL rst_ifIdFlush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.idExBubble_o !== 1'b1) begin errors++; $display("FAIL rst_idExBubble got=%0h exp=1", ha.idExBubble_o); end
        checks++; if (ha.exMemHold_o !== 1'b0) begin errors++; $display("FAIL rst_exMemHold got=%0h exp=0", ha.exMemHold_o); end
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL rst_branch got=%0h exp=0", ha.branch_o); end
        tick();
        checks++; if (ha.stallCount_o !== 16'd0) begin errors++; $display("FAIL rst_stallCount got=%0d exp=0", ha.stallCount_o); end
        checks++; if (hb.stallCount_o !== 3'd0) begin errors++; $display("FAIL rst_stallCount_b got=%0d exp=0", hb.stallCount_o); end
        reset = 1'b0;
        #2;
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL idle_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        checks++; if (ha.ifIdWrite_o !== 1'b1) begin errors++; $display("FAIL idle_ifIdWrite got=%0h exp=1", ha.ifIdWrite_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL idle_ifIdFlush got=%0h exp=0", ha.ifIdFlush_o); end
        checks++; if (ha.idExBubble_o !== 1'b0) begin errors++; $display("FAIL idle_idExBubble got=%0h exp=0", ha.idExBubble_o); end
        checks++; if (ha.branchProgramCounter_o !== 32'd0) begin errors++; $display("FAIL idle_bpc got=%0h exp=0", ha.branchProgramCounter_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        load_hazard();
        #2;
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL lu_c1_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        checks++; if (ha.idExBubble_o !== 1'b1) begin errors++; $display("FAIL lu_c1_bubble got=%0h exp=1", ha.idExBubble_o); end
        checks++; if (ha.ifIdWrite_o !== 1'b0) begin errors++; $display("FAIL lu_c1_ifIdWrite got=%0h exp=0", ha.ifIdWrite_o); end
        tick();
        #2;
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL lu_c2_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        checks++; if (ha.idExBubble_o !== 1'b1) begin errors++; $display("FAIL lu_c2_bubble got=%0h exp=1", ha.idExBubble_o); end
        tick();
        idle();
        #2;
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL lu_c3_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        checks++; if (ha.idExBubble_o !== 1'b0) begin errors++; $display("FAIL lu_c3_bubble got=%0h exp=0", ha.idExBubble_o); end
        checks++; if (ha.stallCount_o !== 16'd2) begin errors++; $display("FAIL lu_stallCount got=%0d exp=2", ha.stallCount_o); end
    endtask

    task automatic test_no_stall();
        do_reset();
        idExMemRead = 1'b1; idExRt = 5'd0; idRs = 5'd0;
        #2;
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL ns_r0_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        idExRt = 5'd7; idRt = 5'd7; idRs = 5'd3; idUsesRt = 1'b0;
        #2;
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL ns_rt_unused_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        idUsesRt = 1'b1;
        #2;
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL ns_rt_used_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        branchTaken = 1'b1; branchTarget = 32'd48;
        #2;
        checks++; if (ha.branch_o !== 1'b1) begin errors++; $display("FAIL br_c1_branch got=%0h exp=1", ha.branch_o); end
        checks++; if (ha.branchProgramCounter_o !== 32'd48) begin errors++; $display("FAIL br_c1_bpc got=%0d exp=48", ha.branchProgramCounter_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL br_c1_flush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL br_c1_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        tick();
        idle();
        #2;
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL br_c2_branch got=%0h exp=0", ha.branch_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL br_c2_flush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL br_c2_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        checks++; if (hb.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL br_c2_flush_b got=%0h exp=0", hb.ifIdFlush_o); end
        tick();
        #2;
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL br_c3_flush got=%0h exp=0", ha.ifIdFlush_o); end
    endtask

    task automatic test_mem_branch();
        do_reset();
        memBusy = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40;
        #2;
        checks++; if (ha.exMemHold_o !== 1'b1) begin errors++; $display("FAIL mb_c1_hold got=%0h exp=1", ha.exMemHold_o); end
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL mb_c1_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL mb_c1_branch got=%0h exp=0", ha.branch_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL mb_c1_flush got=%0h exp=0", ha.ifIdFlush_o); end
        tick();
        branchTaken = 1'b0; branchTarget = '0;
        #2;
        checks++; if (ha.exMemHold_o !== 1'b1) begin errors++; $display("FAIL mb_c2_hold got=%0h exp=1", ha.exMemHold_o); end
        tick();
        #2;
        checks++; if (ha.exMemHold_o !== 1'b1) begin errors++; $display("FAIL mb_c3_hold got=%0h exp=1", ha.exMemHold_o); end
        tick();
        memBusy = 1'b0;
        #2;
        checks++; if (ha.branch_o !== 1'b1) begin errors++; $display("FAIL mb_c4_branch got=%0h exp=1", ha.branch_o); end
        checks++; if (ha.branchProgramCounter_o !== 32'h40) begin errors++; $display("FAIL mb_c4_bpc got=%0h exp=40", ha.branchProgramCounter_o); end
        checks++; if (ha.exMemHold_o !== 1'b0) begin errors++; $display("FAIL mb_c4_hold got=%0h exp=0", ha.exMemHold_o); end
        checks++; if (ha.stallCount_o !== 16'd3) begin errors++; $display("FAIL mb_stallCount got=%0d exp=3", ha.stallCount_o); end
        tick();
        #2;
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL mb_c5_flush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL mb_c5_branch got=%0h exp=0", ha.branch_o); end
        tick();
        #2;
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL mb_c6_flush got=%0h exp=0", ha.ifIdFlush_o); end
    endtask

    task automatic test_interrupted_stall();
        do_reset();
        load_hazard();
        #2;
        checks++; if (hb.pcWrite_o !== 1'b0) begin errors++; $display("FAIL is_c1_pcWrite got=%0h exp=0", hb.pcWrite_o); end
        tick();
        idle();
        memBusy = 1'b1;
        #2;
        checks++; if (hb.exMemHold_o !== 1'b1) begin errors++; $display("FAIL is_c2_hold got=%0h exp=1", hb.exMemHold_o); end
        checks++; if (hb.idExBubble_o !== 1'b0) begin errors++; $display("FAIL is_c2_bubble got=%0h exp=0", hb.idExBubble_o); end
        tick();
        #2;
        checks++; if (hb.pcWrite_o !== 1'b0) begin errors++; $display("FAIL is_c3_pcWrite got=%0h exp=0", hb.pcWrite_o); end
        tick();
        memBusy = 1'b0;
        #2;
        checks++; if (hb.pcWrite_o !== 1'b0) begin errors++; $display("FAIL is_c4_pcWrite got=%0h exp=0", hb.pcWrite_o); end
        checks++; if (hb.idExBubble_o !== 1'b1) begin errors++; $display("FAIL is_c4_bubble got=%0h exp=1", hb.idExBubble_o); end
        checks++; if (hb.exMemHold_o !== 1'b0) begin errors++; $display("FAIL is_c4_hold got=%0h exp=0", hb.exMemHold_o); end
        tick();
        #2;
        checks++; if (hb.pcWrite_o !== 1'b0) begin errors++; $display("FAIL is_c5_pcWrite got=%0h exp=0", hb.pcWrite_o); end
        tick();
        #2;
        checks++; if (hb.pcWrite_o !== 1'b1) begin errors++; $display("FAIL is_c6_pcWrite got=%0h exp=1", hb.pcWrite_o); end
        checks++; if (hb.stallCount_o !== 3'd5) begin errors++; $display("FAIL is_stallCount got=%0d exp=5", hb.stallCount_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        branchTaken = 1'b1; branchTarget = 32'h10;
        #2;
        checks++; if (ha.branchProgramCounter_o !== 32'h10) begin errors++; $display("FAIL bb_c1_bpc got=%0h exp=10", ha.branchProgramCounter_o); end
        tick();
        branchTarget = 32'h20;
        #2;
        checks++; if (ha.branch_o !== 1'b1) begin errors++; $display("FAIL bb_c2_branch got=%0h exp=1", ha.branch_o); end
        checks++; if (ha.branchProgramCounter_o !== 32'h20) begin errors++; $display("FAIL bb_c2_bpc got=%0h exp=20", ha.branchProgramCounter_o); end
        tick();
        idle();
        #2;
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL bb_c3_flush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL bb_c3_branch got=%0h exp=0", ha.branch_o); end
        tick();
        #2;
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL bb_c4_flush got=%0h exp=0", ha.ifIdFlush_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        memBusy = 1'b1;
        repeat (10) tick();
        #2;
        checks++; if (hb.stallCount_o !== 3'd7) begin errors++; $display("FAIL sat_stallCount_b got=%0d exp=7", hb.stallCount_o); end
        checks++; if (ha.stallCount_o !== 16'd10) begin errors++; $display("FAIL sat_stallCount_a got=%0d exp=10", ha.stallCount_o); end
        idle();
    endtask

    task automatic test_reset_pending();
        do_reset();
        load_hazard();
        tick();
        idle();
        memBusy = 1'b1; branchTaken = 1'b1; branchTarget = 32'h80;
        tick();
        idle();
        reset = 1'b1;
        #2;
        checks++; if (ha.pcWrite_o !== 1'b0) begin errors++; $display("FAIL rp_pcWrite got=%0h exp=0", ha.pcWrite_o); end
        checks++; if (ha.ifIdWrite_o !== 1'b0) begin errors++; $display("FAIL rp_ifIdWrite got=%0h exp=0", ha.ifIdWrite_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b1) begin errors++; $display("FAIL rp_flush got=%0h exp=1", ha.ifIdFlush_o); end
        checks++; if (ha.idExBubble_o !== 1'b1) begin errors++; $display("FAIL rp_bubble got=%0h exp=1", ha.idExBubble_o); end
        checks++; if (ha.exMemHold_o !== 1'b0) begin errors++; $display("FAIL rp_hold got=%0h exp=0", ha.exMemHold_o); end
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL rp_branch got=%0h exp=0", ha.branch_o); end
        checks++; if (ha.branchProgramCounter_o !== 32'd0) begin errors++; $display("FAIL rp_bpc got=%0h exp=0", ha.branchProgramCounter_o); end
        tick();
        reset = 1'b0;
        #2;
        checks++; if (ha.branch_o !== 1'b0) begin errors++; $display("FAIL rp_after_branch got=%0h exp=0", ha.branch_o); end
        checks++; if (ha.pcWrite_o !== 1'b1) begin errors++; $display("FAIL rp_after_pcWrite got=%0h exp=1", ha.pcWrite_o); end
        checks++; if (ha.ifIdFlush_o !== 1'b0) begin errors++; $display("FAIL rp_after_flush got=%0h exp=0", ha.ifIdFlush_o); end
        checks++; if (ha.stallCount_o !== 16'd0) begin errors++; $display("FAIL rp_after_stallCount got=%0d exp=0", ha.stallCount_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_branch();
        test_interrupted_stall();
        test_back_to_back();
        test_saturation();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
